// File: rtl/z80_io_initiator.sv
// Wishbone-posted Z80 I/O cycle generator: one IN or OUT per CMD write,
// with programmable setup / strobe / hold timing on the external bus.
module z80_io_initiator #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0100,
    parameter logic [31:0] CMD_ADDRESS    = BASE_ADDRESS,
    parameter logic [31:0] RESULT_ADDRESS = BASE_ADDRESS + 32'd4,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic        wb_stall_out,
    output logic [31:0] wb_data_out,
    output logic [7:0]  z80_address_bus,
    output logic [7:0]  z80_data_bus_out,
    output logic        z80_data_oe,
    input  logic [7:0]  z80_data_bus_in,
    output logic        z80_write_strobe_b,
    output logic        z80_read_strobe_b,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [16:0] r_cmd;
    logic [7:0]  r_in_data;
    logic        r_overrun;

    logic w_req;
    logic w_hit_cmd;
    logic w_hit_res;
    logic w_last;
    logic w_free;
    logic w_accept;
    logic w_ovr_set;
    logic w_res_rd;
    logic w_busy_next;
    logic w_unused;

    assign w_req     = wb_cyc_in & wb_stb_in;
    assign w_hit_cmd = w_req & (wb_addr_in == CMD_ADDRESS);
    assign w_hit_res = w_req & (wb_addr_in == RESULT_ADDRESS);
    assign w_last    = (r_cnt == 8'd0);

    // The final HOLD clock doubles as the first IDLE slot so that a new
    // command can follow with no dead cycle between transactions.
    assign w_free    = (r_state == S_IDLE) |
                       ((r_state == S_HOLD) & w_last);
    assign w_accept  = w_hit_cmd & wb_we_in & w_free;
    assign w_ovr_set = w_hit_cmd & wb_we_in & ~w_free;
    assign w_res_rd  = w_hit_res & ~wb_we_in;

    assign w_busy_next = w_accept |
                         (busy & ~((r_state == S_HOLD) & w_last));

    assign wb_stall_out = 1'b0;
    assign w_unused     = ^wb_data_in[31:17];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_cnt              <= 8'd0;
            r_cmd              <= 17'd0;
            r_in_data          <= 8'd0;
            r_overrun          <= 1'b0;
            wb_ack_out         <= 1'b0;
            wb_data_out        <= 32'd0;
            z80_address_bus    <= 8'd0;
            z80_data_bus_out   <= 8'd0;
            z80_data_oe        <= 1'b0;
            z80_write_strobe_b <= 1'b1;
            z80_read_strobe_b  <= 1'b1;
            busy               <= 1'b0;
        end else begin
            wb_ack_out <= w_hit_cmd | w_hit_res;

            if (w_hit_cmd & ~wb_we_in) begin
                wb_data_out <= {15'd0, r_cmd};
            end else if (w_res_rd) begin
                wb_data_out <= {22'd0, r_overrun, w_busy_next, r_in_data};
            end

            // A collision with a RESULT read keeps the flag set.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_res_rd) begin
                r_overrun <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                end
                S_SETUP: begin
                    if (w_last) begin
                        r_state <= S_STROBE;
                        r_cnt   <= STROBE_LOAD;
                        if (r_cmd[16]) begin
                            z80_write_strobe_b <= 1'b0;
                        end else begin
                            z80_read_strobe_b  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (w_last) begin
                        r_state            <= S_HOLD;
                        r_cnt              <= HOLD_LOAD;
                        z80_write_strobe_b <= 1'b1;
                        z80_read_strobe_b  <= 1'b1;
                        if (!r_cmd[16]) begin
                            r_in_data <= z80_data_bus_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_last) begin
                        r_state     <= S_IDLE;
                        z80_data_oe <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_accept) begin
                r_state         <= S_SETUP;
                r_cnt           <= SETUP_LOAD;
                r_cmd           <= wb_data_in[16:0];
                z80_address_bus <= wb_data_in[7:0];
                z80_data_oe     <= wb_data_in[16];
                busy            <= 1'b1;
                if (wb_data_in[16]) begin
                    z80_data_bus_out <= wb_data_in[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_z80_io_initiator.sv
// Bench for z80_io_initiator: default-timing instance plus a 1/1/1 instance,
// with a read-result scoreboard and per-cycle bus expectations.
module tb_z80_io_initiator;

    localparam logic [31:0] CMD = 32'h3000_0100;
    localparam logic [31:0] RES = 32'h3000_0104;
    localparam logic [31:0] BAD = 32'h3000_0108;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc_a, cyc_b, stb, we;
    logic [31:0] addr, wdata;
    logic [7:0]  bus_in;

    logic        ack_a, stall_a, oe_a, wr_a, rd_a, busy_a;
    logic [31:0] rdata_a;
    logic [7:0]  za_a, zd_a;
    logic        ack_b, stall_b, oe_b, wr_b, rd_b, busy_b;
    logic [31:0] rdata_b;
    logic [7:0]  za_b, zd_b;

    int checks = 0;
    int failures = 0;

    logic [16:0] m_cmd[2];
    logic [7:0]  m_in[2];
    logic [7:0]  m_dout[2];
    logic        m_ovr[2];
    logic [31:0] m_last[2];
    logic [31:0] rq[$];

    int   g_samp = 0;
    int   g_fall = 0;
    int   g_rise = 0;
    logic g_low = 1'b0;

    always #5 clk = ~clk;

    z80_io_initiator dut_a (
        .clk(clk), .reset(reset),
        .wb_cyc_in(cyc_a), .wb_stb_in(stb), .wb_we_in(we),
        .wb_addr_in(addr), .wb_data_in(wdata),
        .wb_ack_out(ack_a), .wb_stall_out(stall_a),
        .wb_data_out(rdata_a),
        .z80_address_bus(za_a), .z80_data_bus_out(zd_a),
        .z80_data_oe(oe_a), .z80_data_bus_in(bus_in),
        .z80_write_strobe_b(wr_a), .z80_read_strobe_b(rd_a),
        .busy(busy_a)
    );

    z80_io_initiator #(
        .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .wb_cyc_in(cyc_b), .wb_stb_in(stb), .wb_we_in(we),
        .wb_addr_in(addr), .wb_data_in(wdata),
        .wb_ack_out(ack_b), .wb_stall_out(stall_b),
        .wb_data_out(rdata_b),
        .z80_address_bus(za_b), .z80_data_bus_out(zd_b),
        .z80_data_oe(oe_b), .z80_data_bus_in(bus_in),
        .z80_write_strobe_b(wr_b), .z80_read_strobe_b(rd_b),
        .busy(busy_b)
    );

    function automatic logic [19:0] obs(input bit sel);
        if (sel) return {busy_b, wr_b, rd_b, oe_b, za_b, zd_b};
        return {busy_a, wr_a, rd_a, oe_a, za_a, zd_a};
    endfunction

    function automatic logic ack_of(input bit sel);
        return sel ? ack_b : ack_a;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? rdata_b : rdata_a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cmd[i]  = '0;
            m_in[i]   = '0;
            m_dout[i] = '0;
            m_ovr[i]  = 1'b0;
            m_last[i] = '0;
        end
    endtask

    task automatic issue(input bit sel, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        cyc_a = !sel;
        cyc_b = sel;
        stb   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic release_bus();
        cyc_a = 1'b0;
        cyc_b = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic write_cmd(input bit sel, input logic [31:0] d);
        issue(sel, 1'b1, CMD, d);
        @(negedge clk);
        release_bus();
        checks++;
        if (ack_of(sel) !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ack: ack=%b required 1", ack_of(sel));
        end
        m_cmd[sel] = d[16:0];
        if (d[16]) m_dout[sel] = d[15:8];
    endtask

    task automatic wb_read(input bit sel, input logic [31:0] a);
        logic [31:0] exp;
        if (a == CMD) exp = {15'd0, m_cmd[sel]};
        else exp = {22'd0, m_ovr[sel], 1'b0, m_in[sel]};
        rq.push_back(exp);
        issue(sel, 1'b0, a, 32'd0);
        @(negedge clk);
        release_bus();
        checks++;
        if (ack_of(sel) !== 1'b1) begin
            failures++;
            $display("FAIL read_ack addr=%h: ack=%b required 1",
                     a, ack_of(sel));
            void'(rq.pop_front());
        end else begin
            exp = rq.pop_front();
            m_last[sel] = exp;
            if (rdata_of(sel) !== exp) begin
                failures++;
                $display("FAIL read_data addr=%h: got %h required %h",
                         a, rdata_of(sel), exp);
            end
        end
        if (a == RES) m_ovr[sel] = 1'b0;
    endtask

    // Starts at sample k=1 (just after the accepting edge).
    task automatic run_txn(input bit sel, input bit dir,
                           input logic [7:0] pa, input logic [7:0] in_v,
                           input int s, input int t, input int h,
                           input int nk, input int inj_k,
                           input logic [31:0] inj_d);
        logic [19:0] e, o;
        logic        lowv, act;
        int          nb, tot;
        nb  = 0;
        tot = s + t + h;
        for (int k = 1; k <= nk; k++) begin
            if (inj_k != 0 && k == inj_k + 1) begin
                release_bus();
                checks++;
                if (ack_of(sel) !== 1'b1) begin
                    failures++;
                    $display("FAIL inj_ack: ack=%b required 1", ack_of(sel));
                end
            end
            act      = (k > s) && (k <= s + t);
            e[19]    = (k <= tot);
            e[18]    = !(dir && act);
            e[17]    = !(!dir && act);
            e[16]    = dir && (k <= tot);
            e[15:8]  = pa;
            e[7:0]   = m_dout[sel];
            o = obs(sel);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL txn k=%0d: got %h required %h", k, o, e);
            end
            if (o[19]) nb++;
            lowv = !(o[18] & o[17]);
            g_samp++;
            if (lowv && !g_low) g_fall = g_samp;
            if (!lowv && g_low) g_rise = g_samp;
            g_low = lowv;
            bus_in = act ? in_v : 8'hFF;
            if (k == inj_k) issue(sel, 1'b1, CMD, inj_d);
            @(negedge clk);
        end
        if (inj_k != 0 && inj_k == nk) begin
            release_bus();
            checks++;
            if (ack_of(sel) !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ack: ack=%b required 1", ack_of(sel));
            end
        end
        checks++;
        if (nb != tot) begin
            failures++;
            $display("FAIL busy_len: got %0d required %0d", nb, tot);
        end
        if (!dir) m_in[sel] = in_v;
        if (inj_k != 0) begin
            if (inj_k == tot) begin
                m_cmd[sel] = inj_d[16:0];
                if (inj_d[16]) m_dout[sel] = inj_d[15:8];
            end else begin
                m_ovr[sel] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i[0]) !== 20'h6_0000) begin
                failures++;
                $display("FAIL reset_bus dut%0d: got %h required 60000",
                         i, obs(i[0]));
            end
        end
        checks++;
        if ({ack_a, stall_a, rdata_a, ack_b, stall_b, rdata_b} !== '0) begin
            failures++;
            $display("FAIL reset_wb: got %b%b%h %b%b%h required zeros",
                     ack_a, stall_a, rdata_a, ack_b, stall_b, rdata_b);
        end
    endtask

    task automatic test_out();
        write_cmd(1'b0, 32'h0001_5A80);
        run_txn(1'b0, 1'b1, 8'h80, 8'h00, 2, 4, 2, 9, 0, 32'd0);
    endtask

    task automatic test_in();
        write_cmd(1'b0, 32'h0000_0081);
        run_txn(1'b0, 1'b0, 8'h81, 8'hC3, 2, 4, 2, 9, 0, 32'd0);
        wb_read(1'b0, RES);
    endtask

    task automatic test_overrun();
        write_cmd(1'b0, 32'h0001_A510);
        run_txn(1'b0, 1'b1, 8'h10, 8'h00, 2, 4, 2, 9, 4, 32'h0001_FF22);
        wb_read(1'b0, RES);
        wb_read(1'b0, RES);
        wb_read(1'b0, CMD);
    endtask

    task automatic test_back_to_back();
        int r1;
        g_low = 1'b0;
        write_cmd(1'b0, 32'h0001_1120);
        run_txn(1'b0, 1'b1, 8'h20, 8'h00, 2, 4, 2, 8, 8, 32'h0000_0021);
        r1 = g_rise;
        run_txn(1'b0, 1'b0, 8'h21, 8'h5E, 2, 4, 2, 9, 0, 32'd0);
        checks++;
        if (g_fall - r1 != 4) begin
            failures++;
            $display("FAIL b2b_gap: got %0d required 4", g_fall - r1);
        end
        wb_read(1'b0, RES);
    endtask

    task automatic test_reset_mid();
        logic [19:0] o;
        write_cmd(1'b0, 32'h0000_0042);
        for (int k = 1; k <= 3; k++) begin
            bus_in = (k >= 3) ? 8'hAA : 8'hFF;
            @(negedge clk);
        end
        reset = 1'b1;
        bus_in = 8'hAA;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        o = obs(1'b0);
        checks++;
        if (o[19:16] !== 4'b0110) begin
            failures++;
            $display("FAIL mid_reset: got %b required 0110", o[19:16]);
        end
        wb_read(1'b0, RES);
        wb_read(1'b0, CMD);
        write_cmd(1'b0, 32'h0001_6633);
        run_txn(1'b0, 1'b1, 8'h33, 8'h00, 2, 4, 2, 9, 0, 32'd0);
    endtask

    task automatic test_unmapped();
        issue(1'b0, 1'b1, BAD, 32'h0001_0077);
        @(negedge clk);
        release_bus();
        checks++;
        if (ack_a !== 1'b0) begin
            failures++;
            $display("FAIL bad_wr_ack: ack=%b required 0", ack_a);
        end
        @(negedge clk);
        checks++;
        if ({ack_a, busy_a} !== 2'b00) begin
            failures++;
            $display("FAIL bad_wr_state: ack,busy=%b%b required 00",
                     ack_a, busy_a);
        end
        issue(1'b0, 1'b0, BAD, 32'd0);
        @(negedge clk);
        release_bus();
        checks++;
        if ({ack_a, rdata_a} !== {1'b0, m_last[0]}) begin
            failures++;
            $display("FAIL bad_rd: ack=%b data=%h required 0 %h",
                     ack_a, rdata_a, m_last[0]);
        end
        @(negedge clk);
        wb_read(1'b0, CMD);
    endtask

    task automatic test_short();
        write_cmd(1'b1, 32'h0001_C344);
        run_txn(1'b1, 1'b1, 8'h44, 8'h00, 1, 1, 1, 4, 0, 32'd0);
        write_cmd(1'b1, 32'h0000_0045);
        run_txn(1'b1, 1'b0, 8'h45, 8'h96, 1, 1, 1, 4, 0, 32'd0);
        wb_read(1'b1, RES);
        wb_read(1'b1, CMD);
    endtask

    initial begin
        reset  = 1'b1;
        cyc_a  = 1'b0;
        cyc_b  = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        bus_in = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_out();
        test_in();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_unmapped();
        test_short();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
